// File: rtl/alu_issue_queue.sv
// ============================================================================
// Module  : alu_issue_queue
// Purpose : Collapsing, age-ordered issue queue feeding one ALU pipeline.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_queue #(
  parameter int IQ_ENTRIES         = 8,
  parameter int PRF_BANK_COUNT     = 4,
  parameter int LOG_PRF_BANK_COUNT = 2,
  parameter int LOG_PR_COUNT       = 7,
  parameter int LOG_ROB_ENTRIES    = 6
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     dispatch_valid_in,
  output logic                                     dispatch_ready_out,
  input  logic [3:0]                               dispatch_op_in,
  input  logic                                     dispatch_is_imm_in,
  input  logic [31:0]                              dispatch_imm_in,
  input  logic                                     dispatch_A_unneeded_in,
  input  logic [LOG_PR_COUNT-1:0]                  dispatch_A_PR_in,
  input  logic                                     dispatch_A_ready_in,
  input  logic [LOG_PR_COUNT-1:0]                  dispatch_B_PR_in,
  input  logic                                     dispatch_B_ready_in,
  input  logic [LOG_PR_COUNT-1:0]                  dispatch_dest_PR_in,
  input  logic [LOG_ROB_ENTRIES-1:0]               dispatch_ROB_index_in,
  input  logic [PRF_BANK_COUNT-1:0]                wakeup_valid_by_bank_in,
  input  logic [PRF_BANK_COUNT*LOG_PR_COUNT-1:0]   wakeup_PR_by_bank_in,
  input  logic                                     issue_ready_in,
  output logic                                     issue_valid_out,
  output logic [3:0]                               issue_op_out,
  output logic                                     issue_is_imm_out,
  output logic [31:0]                              issue_imm_out,
  output logic                                     issue_A_unneeded_out,
  output logic                                     issue_A_forward_out,
  output logic [LOG_PRF_BANK_COUNT-1:0]            issue_A_bank_out,
  output logic                                     issue_B_forward_out,
  output logic [LOG_PRF_BANK_COUNT-1:0]            issue_B_bank_out,
  output logic [LOG_PR_COUNT-1:0]                  issue_dest_PR_out,
  output logic [LOG_ROB_ENTRIES-1:0]               issue_ROB_index_out,
  output logic                                     PRF_A_req_valid_out,
  output logic [LOG_PR_COUNT-1:0]                  PRF_A_req_PR_out,
  output logic                                     PRF_B_req_valid_out,
  output logic [LOG_PR_COUNT-1:0]                  PRF_B_req_PR_out
);

  localparam int IDXW = $clog2(IQ_ENTRIES);
  localparam int CW   = IDXW + 1;
  localparam int LB   = LOG_PRF_BANK_COUNT;

  typedef struct packed {
    logic [3:0]                 op;
    logic                       is_imm;
    logic [31:0]                imm;
    logic                       a_un;
    logic [LOG_PR_COUNT-1:0]    a_pr;
    logic                       a_rdy;
    logic [LOG_PR_COUNT-1:0]    b_pr;
    logic                       b_rdy;
    logic [LOG_PR_COUNT-1:0]    dest;
    logic [LOG_ROB_ENTRIES-1:0] rob;
  } entry_t;

  entry_t                  r_q [IQ_ENTRIES];
  logic [CW-1:0]           r_count;

  logic [LOG_PR_COUNT-1:0] w_wk_pr [PRF_BANK_COUNT];
  entry_t                  w_upd   [IQ_ENTRIES];
  entry_t                  w_nxt   [IQ_ENTRIES];
  logic [IQ_ENTRIES-1:0]   w_a_match;
  logic [IQ_ENTRIES-1:0]   w_b_match;
  logic [IQ_ENTRIES-1:0]   w_cand;
  logic [IDXW-1:0]         w_sel;
  logic                    w_found;
  logic                    w_issue_fire;
  logic                    w_disp_fire;
  logic [IDXW-1:0]         w_dst;
  entry_t                  w_new;
  entry_t                  w_s;

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_wk
    assign w_wk_pr[b] = wakeup_PR_by_bank_in[b*LOG_PR_COUNT +: LOG_PR_COUNT];
  end

  // A tag only ever broadcasts on the bank named by its low bits.
  function automatic logic f_match(input logic [LOG_PR_COUNT-1:0] pr);
    logic [LB-1:0] bank;
    bank = pr[LB-1:0];
    return wakeup_valid_by_bank_in[bank] && (w_wk_pr[bank] == pr);
  endfunction

  assign dispatch_ready_out = (r_count < CW'(IQ_ENTRIES));
  assign w_disp_fire        = dispatch_valid_in && dispatch_ready_out;
  assign w_issue_fire       = w_found && issue_ready_in;
  assign w_dst              = r_count[IDXW-1:0] - IDXW'(w_issue_fire);

  always_comb begin
    w_new        = '0;
    w_new.op     = dispatch_op_in;
    w_new.is_imm = dispatch_is_imm_in;
    w_new.imm    = dispatch_imm_in;
    w_new.a_un   = dispatch_A_unneeded_in;
    w_new.a_pr   = dispatch_A_PR_in;
    w_new.a_rdy  = dispatch_A_ready_in | f_match(dispatch_A_PR_in);
    w_new.b_pr   = dispatch_B_PR_in;
    w_new.b_rdy  = dispatch_B_ready_in | f_match(dispatch_B_PR_in);
    w_new.dest   = dispatch_dest_PR_in;
    w_new.rob    = dispatch_ROB_index_in;
  end

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      w_a_match[i]    = f_match(r_q[i].a_pr);
      w_b_match[i]    = f_match(r_q[i].b_pr);
      w_cand[i]       = (CW'(i) < r_count)
                        && (r_q[i].a_un   || r_q[i].a_rdy || w_a_match[i])
                        && (r_q[i].is_imm || r_q[i].b_rdy || w_b_match[i]);
      w_upd[i]        = r_q[i];
      w_upd[i].a_rdy  = r_q[i].a_rdy | w_a_match[i];
      w_upd[i].b_rdy  = r_q[i].b_rdy | w_b_match[i];
    end
    // Scan from the top so the oldest candidate is the one that sticks.
    for (int i = IQ_ENTRIES - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_found = 1'b1;
        w_sel   = IDXW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      if (w_issue_fire && (i >= int'(w_sel)) && (i < IQ_ENTRIES - 1)) begin
        w_nxt[i] = w_upd[(i < IQ_ENTRIES - 1) ? i + 1 : i];
      end else begin
        w_nxt[i] = w_upd[i];
      end
    end
    if (w_disp_fire) begin
      w_nxt[w_dst] = w_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_disp_fire) - CW'(w_issue_fire);
    end
  end

  // Slots at or above count are dead, so payload needs no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      r_q[i] <= w_nxt[i];
    end
  end

  assign w_s                  = r_q[w_sel];
  assign issue_valid_out      = w_found;
  assign issue_op_out         = w_s.op;
  assign issue_is_imm_out     = w_s.is_imm;
  assign issue_imm_out        = w_s.imm;
  assign issue_A_unneeded_out = w_s.a_un;
  assign issue_A_forward_out  = !w_s.a_un && !w_s.a_rdy && w_a_match[w_sel];
  assign issue_A_bank_out     = w_s.a_pr[LB-1:0];
  assign issue_B_forward_out  = !w_s.is_imm && !w_s.b_rdy && w_b_match[w_sel];
  assign issue_B_bank_out     = w_s.b_pr[LB-1:0];
  assign issue_dest_PR_out    = w_s.dest;
  assign issue_ROB_index_out  = w_s.rob;
  assign PRF_A_req_valid_out  = w_found && !w_s.a_un && !issue_A_forward_out;
  assign PRF_A_req_PR_out     = w_s.a_pr;
  assign PRF_B_req_valid_out  = w_found && !w_s.is_imm && !issue_B_forward_out;
  assign PRF_B_req_PR_out     = w_s.b_pr;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// ============================================================================
// Module  : tb_alu_issue_queue
// Purpose : Randomized and directed bench for alu_issue_queue against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_queue;

  localparam int N = 8;

  logic        clk;
  logic        rst;
  logic        d_valid;
  logic        d_ready;
  logic [3:0]  d_op;
  logic        d_is_imm;
  logic [31:0] d_imm;
  logic        d_a_un;
  logic [6:0]  d_a_pr;
  logic        d_a_rdy;
  logic [6:0]  d_b_pr;
  logic        d_b_rdy;
  logic [6:0]  d_dest;
  logic [5:0]  d_rob;
  logic [3:0]  wk_v;
  logic [6:0]  wk_pr [4];
  logic [27:0] wk_flat;
  logic        i_rdy;
  logic        o_valid;
  logic [3:0]  o_op;
  logic        o_is_imm;
  logic [31:0] o_imm;
  logic        o_a_un;
  logic        o_a_fwd;
  logic [1:0]  o_a_bank;
  logic        o_b_fwd;
  logic [1:0]  o_b_bank;
  logic [6:0]  o_dest;
  logic [5:0]  o_rob;
  logic        o_pa_v;
  logic [6:0]  o_pa_pr;
  logic        o_pb_v;
  logic [6:0]  o_pb_pr;

  assign wk_flat = {wk_pr[3], wk_pr[2], wk_pr[1], wk_pr[0]};

  alu_issue_queue dut (
    .CLK(clk), .RST(rst),
    .dispatch_valid_in(d_valid), .dispatch_ready_out(d_ready),
    .dispatch_op_in(d_op), .dispatch_is_imm_in(d_is_imm), .dispatch_imm_in(d_imm),
    .dispatch_A_unneeded_in(d_a_un), .dispatch_A_PR_in(d_a_pr), .dispatch_A_ready_in(d_a_rdy),
    .dispatch_B_PR_in(d_b_pr), .dispatch_B_ready_in(d_b_rdy),
    .dispatch_dest_PR_in(d_dest), .dispatch_ROB_index_in(d_rob),
    .wakeup_valid_by_bank_in(wk_v), .wakeup_PR_by_bank_in(wk_flat),
    .issue_ready_in(i_rdy), .issue_valid_out(o_valid), .issue_op_out(o_op),
    .issue_is_imm_out(o_is_imm), .issue_imm_out(o_imm), .issue_A_unneeded_out(o_a_un),
    .issue_A_forward_out(o_a_fwd), .issue_A_bank_out(o_a_bank),
    .issue_B_forward_out(o_b_fwd), .issue_B_bank_out(o_b_bank),
    .issue_dest_PR_out(o_dest), .issue_ROB_index_out(o_rob),
    .PRF_A_req_valid_out(o_pa_v), .PRF_A_req_PR_out(o_pa_pr),
    .PRF_B_req_valid_out(o_pb_v), .PRF_B_req_PR_out(o_pb_pr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        is_imm;
    logic [31:0] imm;
    logic        a_un;
    logic [6:0]  a_pr;
    logic        a_rdy;
    logic [6:0]  b_pr;
    logic        b_rdy;
    logic [6:0]  dest;
    logic [5:0]  rob;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit woken(input logic [6:0] pr);
    int b;
    b = int'(pr) % 4;
    return wk_v[b] && (wk_pr[b] == pr);
  endfunction

  // Inputs are already driven; compare against the model, then advance it one clock.
  task automatic step();
    int   sel;
    bit   found;
    bit   fa, fb, was_full;
    ent_t e;
    ent_t n;
    #1;
    check_eq("dispatch_ready", d_ready, q.size() < N);
    found = 0;
    sel   = 0;
    foreach (q[i]) begin
      if (!found && (q[i].a_un || q[i].a_rdy || woken(q[i].a_pr))
                 && (q[i].is_imm || q[i].b_rdy || woken(q[i].b_pr))) begin
        found = 1;
        sel   = i;
      end
    end
    check_eq("issue_valid", o_valid, found);
    if (found) begin
      e  = q[sel];
      fa = !e.a_un && !e.a_rdy && woken(e.a_pr);
      fb = !e.is_imm && !e.b_rdy && woken(e.b_pr);
      check_eq("op", o_op, e.op);
      check_eq("is_imm", o_is_imm, e.is_imm);
      check_eq("imm", o_imm, e.imm);
      check_eq("a_unneeded", o_a_un, e.a_un);
      check_eq("a_forward", o_a_fwd, fa);
      check_eq("a_bank", o_a_bank, e.a_pr % 4);
      check_eq("b_forward", o_b_fwd, fb);
      check_eq("b_bank", o_b_bank, e.b_pr % 4);
      check_eq("dest", o_dest, e.dest);
      check_eq("rob", o_rob, e.rob);
      check_eq("prf_a_valid", o_pa_v, !e.a_un && !fa);
      check_eq("prf_b_valid", o_pb_v, !e.is_imm && !fb);
      if (!e.a_un && !fa) check_eq("prf_a_pr", o_pa_pr, e.a_pr);
      if (!e.is_imm && !fb) check_eq("prf_b_pr", o_pb_pr, e.b_pr);
    end else begin
      check_eq("prf_a_valid_idle", o_pa_v, 1'b0);
      check_eq("prf_b_valid_idle", o_pb_v, 1'b0);
    end

    was_full = (q.size() >= N);
    if (rst) begin
      q.delete();
    end else begin
      foreach (q[i]) begin
        if (woken(q[i].a_pr)) q[i].a_rdy = 1'b1;
        if (woken(q[i].b_pr)) q[i].b_rdy = 1'b1;
      end
      if (found && i_rdy) q.delete(sel);
      if (d_valid && !was_full) begin
        n.op = d_op; n.is_imm = d_is_imm; n.imm = d_imm; n.a_un = d_a_un;
        n.a_pr = d_a_pr; n.a_rdy = d_a_rdy | woken(d_a_pr);
        n.b_pr = d_b_pr; n.b_rdy = d_b_rdy | woken(d_b_pr);
        n.dest = d_dest; n.rob = d_rob;
        q.push_back(n);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; d_valid = 0; d_op = 0; d_is_imm = 0; d_imm = 0; d_a_un = 0;
    d_a_pr = 0; d_a_rdy = 0; d_b_pr = 0; d_b_rdy = 0; d_dest = 0; d_rob = 0;
    wk_v = 0; i_rdy = 1;
    for (int b = 0; b < 4; b++) wk_pr[b] = 7'(b);
  endtask

  initial begin
    @(negedge clk);
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    step();

    // Both operands ready at dispatch: issues next cycle via the PRF path.
    d_valid = 1; d_op = 4'd3; d_a_pr = 7'h11; d_a_rdy = 1; d_b_pr = 7'h22; d_b_rdy = 1;
    d_dest = 7'h15; d_rob = 6'd9;
    step();
    d_valid = 0;
    step();
    step();

    // A waits on bank 2, B immediate; wakeup two cycles later forwards.
    d_valid = 1; d_a_pr = 7'h26; d_a_rdy = 0; d_is_imm = 1; d_imm = 32'hDEAD_BEEF;
    step();
    d_valid = 0;
    step();
    wk_v = 4'b0100; wk_pr[2] = 7'h26;
    step();
    wk_v = 0;
    step();

    // Same, but the pipeline stalls through the wakeup.
    d_valid = 1;
    step();
    d_valid = 0;
    step();
    i_rdy = 0; wk_v = 4'b0100;
    step();
    wk_v = 0; i_rdy = 1;
    step();
    step();

    // Fill the queue with ops that wait on distinct B tags, then wake entry 5.
    d_is_imm = 0; d_a_un = 1;
    for (int k = 0; k < 9; k++) begin
      d_valid = 1; d_b_pr = 7'(8'h40 + k); d_b_rdy = 0; d_rob = 6'(k);
      step();
    end
    d_valid = 1; d_b_pr = 7'h50;
    wk_v = 4'b0010; wk_pr[1] = 7'h45;
    step();
    wk_v = 0; d_valid = 0;
    step();
    // Wake entries 1 and 3 together.
    wk_v = 4'b1010; wk_pr[1] = 7'h41; wk_pr[3] = 7'h43;
    step();
    wk_v = 0;
    step();
    step();
    // Reset with entries held and dispatch requested.
    rst = 1; d_valid = 1;
    step();
    rst = 0; d_valid = 0;
    step();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int t;
      rst      = ($urandom_range(0, 149) == 0);
      d_valid  = ($urandom_range(0, 9) < 6);
      d_op     = 4'($urandom);
      d_is_imm = ($urandom_range(0, 3) == 0);
      d_imm    = $urandom;
      d_a_un   = ($urandom_range(0, 5) == 0);
      t        = $urandom_range(0, 15);
      d_a_pr   = 7'(t);
      d_a_rdy  = ($urandom_range(0, 3) == 0);
      t        = $urandom_range(0, 15);
      d_b_pr   = 7'(t);
      d_b_rdy  = ($urandom_range(0, 3) == 0);
      d_dest   = 7'($urandom);
      d_rob    = 6'($urandom);
      i_rdy    = ($urandom_range(0, 9) < 7);
      for (int b = 0; b < 4; b++) begin
        wk_v[b]  = ($urandom_range(0, 9) < 3);
        t        = $urandom_range(0, 3) * 4 + b;
        wk_pr[b] = 7'(t);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
